inject_arbiter: RTL and testbench
=================================

Name: inject_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one NoC injection port among NUM_SRC injector sources.
- Typical sources: application parser, mapper-task injector, debug injector.
- Each source uses the tx/credit/data flit handshake. A grant is held for as long as the granted source keeps tx asserted, so one source's application stream (descriptor plus all task binaries) is never interleaved with another's.
- Also aggregates per-source end-of-applications flags into a single eoa_o.

Parameters:
- FLIT_SIZE, 32, width of one flit in bits.
- NUM_SRC, 4, number of injector sources (2..16).
- SRC_W, $clog2(NUM_SRC), width of the grant index.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- src_tx_i  in  NUM_SRC  per-source flit-valid; held high for the entire stream.
- src_data_i  in  NUM_SRC*FLIT_SIZE  per-source flit data; source k occupies bits [k*FLIT_SIZE +: FLIT_SIZE].
- src_credit_o  out  NUM_SRC  per-source credit; only the granted source ever sees 1.
- src_eoa_i  in  NUM_SRC  per-source end-of-applications; sticky high once asserted.
- tx_o  out  1  flit-valid to the NoC injection port.
- data_o  out  FLIT_SIZE  flit to the NoC.
- credit_i  in  1  NoC credit; a flit transfers on a rising edge where tx_o && credit_i.
- eoa_o  out  1  all sources have finished and the port is idle.
- busy_o  out  1  FSM is in GRANT.
- grant_o  out  SRC_W  index of the current or last granted source.
- flit_cnt_o  out  32  flits transferred in the current or last grant.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - state=IDLE, last_q=NUM_SRC-1, grant_q=0, flit_cnt_q=0.
  - All outputs 0: tx_o, data_o, src_credit_o, eoa_o, busy_o, grant_o, flit_cnt_o.
  - Reset asserted mid-stream aborts the grant immediately. No flit is in flight afterwards.
- FSM state IDLE:
  - tx_o=0, data_o=0, src_credit_o=0.
  - If any src_tx_i is high at a rising edge:
    - Pick the first high index searching from (last_q+1) mod NUM_SRC upward, wrapping.
    - grant_q<=that index, flit_cnt_q<=0, state<=GRANT.
  - Otherwise remain in IDLE.
- FSM state GRANT, with g=grant_q:
  - Combinational pass-through: tx_o=src_tx_i[g], data_o=src_data_i[g] when src_tx_i[g] is high (else 0), src_credit_o[g]=credit_i, all other credits 0.
  - Each rising edge with src_tx_i[g] && credit_i increments flit_cnt_q.
  - flit_cnt_q saturates at 2^32-1 and does not wrap.
  - When src_tx_i[g] is low at a rising edge: state<=IDLE, last_q<=g. The grant is released. flit_cnt_q and grant_q hold their values for observation.
  - Other sources' tx changes are ignored while in GRANT.
- Arbitration latency:
  - A request seen in IDLE gets its first possible transfer on the edge one cycle after the grant edge.
  - Re-arbitration costs exactly one IDLE cycle between consecutive grants. There are no back-to-back grants without an IDLE cycle.
- Fairness:
  - A source that just released cannot win again while any other source requests.
  - A sole requester is re-granted after its single IDLE cycle.
- busy_o = (state==GRANT).
- grant_o = grant_q. flit_cnt_o = flit_cnt_q.
- eoa_o is a registered output: eoa_o <= (&src_eoa_i) && state==IDLE && ~|src_tx_i.
  - It is 1 one cycle after the condition holds.
  - It drops if the condition breaks (e.g. a late tx arrives).
- A source whose tx stays high with credit_i held low stalls the port indefinitely. There is no timeout, and the arbiter never preempts.
- data_o changes only through source data. The arbiter does not register data, so latency from src_data_i to data_o is 0 cycles.

Test Plan:
- Reset then a single source: src_tx_i=0001, 5 flits 0xA0..0xA4, credit_i=1 -> grant_o=0; tx_o high from the cycle after the grant edge; data_o sequence A0..A4; flit_cnt_o=5; back to IDLE one cycle after tx drops.
- Contention, NUM_SRC=4, src_tx_i=1011 raised simultaneously, each source sends 3 flits then drops tx and re-raises it -> grant order 0,1,3,0; exactly one IDLE cycle between grants; no interleaved flits.
- Backpressure: granted source 2, credit_i toggles 1,0,0,1,1 -> only flits at credit=1 edges count; flit_cnt_o=3; src_credit_o=0100 mirrors credit_i; other credits stay 0.
- Lock: source 1 granted and streaming; source 0 raises tx mid-stream -> source 0 gets src_credit_o[0]=0 until source 1 releases; then grant_o=0.
- Reset mid-stream after 2 of 6 flits from source 3 -> tx_o, credits and busy_o drop asynchronously to 0. After release, arbitration restarts from source 0 (last_q=3).
- EOA: src_eoa_i goes to 1111 while source 2 is still streaming -> eoa_o stays 0; eoa_o rises 1 cycle after IDLE is entered with no tx pending, and falls if src_tx_i[1] is then raised.

Source files
------------

// File: rtl/inject_arbiter.sv
// Round-robin, packet-locked arbiter sharing one NoC injection port among NUM_SRC sources.
// A grant is held while the granted source keeps tx high; eoa_o aggregates per-source end flags.
module inject_arbiter #(
    parameter int FLIT_SIZE = 32,
    parameter int NUM_SRC   = 4,
    parameter int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_SRC-1:0]             src_tx_i,
    input  logic [NUM_SRC*FLIT_SIZE-1:0]   src_data_i,
    output logic [NUM_SRC-1:0]             src_credit_o,
    input  logic [NUM_SRC-1:0]             src_eoa_i,
    output logic                           tx_o,
    output logic [FLIT_SIZE-1:0]           data_o,
    input  logic                           credit_i,
    output logic                           eoa_o,
    output logic                           busy_o,
    output logic [SRC_W-1:0]               grant_o,
    output logic [31:0]                    flit_cnt_o
);

    // Handshake: a flit moves on a rising edge where tx_o && credit_i; the granted
    // source sees credit_i on its own credit line, every other source sees 0.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SRC_W-1:0]       r_last;
    logic [SRC_W-1:0]       r_grant;
    logic [31:0]            r_flit_cnt;
    logic                   r_eoa;

    logic [SRC_W-1:0]       w_pick;
    logic                   w_found;
    int                     w_best_d;
    int                     w_d;
    logic                   w_sel_tx;
    logic [FLIT_SIZE-1:0]   w_sel_data;

    // Distance from (last+1) mod NUM_SRC; the smallest distance among requesters wins.
    always_comb begin
        w_found  = 1'b0;
        w_pick   = '0;
        w_best_d = NUM_SRC;
        w_d      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_d = (k + 2 * NUM_SRC - int'(r_last) - 1) % NUM_SRC;
            if (src_tx_i[k] && (w_d < w_best_d)) begin
                w_best_d = w_d;
                w_pick   = SRC_W'(k);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_tx     = 1'b0;
        w_sel_data   = '0;
        src_credit_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (r_grant == SRC_W'(k)) begin
                w_sel_tx   = src_tx_i[k];
                w_sel_data = src_data_i[k*FLIT_SIZE +: FLIT_SIZE];
                if (r_state == GRANT) begin
                    src_credit_o[k] = credit_i;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found)   w_next = GRANT;
            GRANT:   if (!w_sel_tx) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // grant and count are left untouched on release so they stay observable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last     <= SRC_W'(NUM_SRC - 1);
            r_grant    <= '0;
            r_flit_cnt <= '0;
            r_eoa      <= 1'b0;
        end else begin
            r_eoa <= (&src_eoa_i) && (r_state == IDLE) && !(|src_tx_i);
            if (r_state == IDLE) begin
                if (w_found) begin
                    r_grant    <= w_pick;
                    r_flit_cnt <= '0;
                end
            end else if (!w_sel_tx) begin
                r_last <= r_grant;
            end else if (credit_i && (r_flit_cnt != 32'hFFFF_FFFF)) begin
                r_flit_cnt <= r_flit_cnt + 32'd1;
            end
        end
    end

    assign tx_o       = (r_state == GRANT) && w_sel_tx;
    assign data_o     = tx_o ? w_sel_data : '0;
    assign busy_o     = (r_state == GRANT);
    assign grant_o    = r_grant;
    assign flit_cnt_o = r_flit_cnt;
    assign eoa_o      = r_eoa;

endmodule

// File: tb/tb_inject_arbiter.sv
// Randomized bench for inject_arbiter: sources stream random-length packets under random
// credit, and an owner/last-served reference model predicts every output each cycle.
module tb_inject_arbiter;

    localparam int N  = 4;
    localparam int FW = 32;
    localparam int SW = $clog2(N);

    logic              clk_i;
    logic              rst_ni;
    logic [N-1:0]      src_tx_i;
    logic [N*FW-1:0]   src_data_i;
    logic [N-1:0]      src_credit_o;
    logic [N-1:0]      src_eoa_i;
    logic              tx_o;
    logic [FW-1:0]     data_o;
    logic              credit_i;
    logic              eoa_o;
    logic              busy_o;
    logic [SW-1:0]     grant_o;
    logic [31:0]       flit_cnt_o;

    inject_arbiter #(.FLIT_SIZE(FW), .NUM_SRC(N)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .src_tx_i     (src_tx_i),
        .src_data_i   (src_data_i),
        .src_credit_o (src_credit_o),
        .src_eoa_i    (src_eoa_i),
        .tx_o         (tx_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .eoa_o        (eoa_o),
        .busy_o       (busy_o),
        .grant_o      (grant_o),
        .flit_cnt_o   (flit_cnt_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // reference model: owner = granted source or -1 when idle
    int           m_owner;
    int           m_last;
    int           m_grant;
    logic [31:0]  m_cnt;
    logic         m_eoa;

    // source-side stimulus state
    logic [N-1:0]  b_tx;
    logic [N-1:0]  b_eoa;
    logic [FW-1:0] cur[N];
    int            rem[N];
    bit            cool[N];
    bit            allow_new;
    bit            did_reset;
    bit            eoa_seen;

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            if (req[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_grant = 0;
        m_cnt   = '0;
        m_eoa   = 1'b0;
    endtask

    task automatic apply_inputs();
        src_tx_i  = b_tx;
        src_eoa_i = b_eoa;
        for (int k = 0; k < N; k++) src_data_i[k*FW +: FW] = cur[k];
    endtask

    task automatic check_regs();
        check("busy",     32'(busy_o),  32'(m_owner >= 0));
        check("grant",    32'(grant_o), 32'(m_grant));
        check("flit_cnt", flit_cnt_o,   m_cnt);
        check("eoa",      32'(eoa_o),   32'(m_eoa));
    endtask

    task automatic check_comb();
        logic          e_tx;
        logic [FW-1:0] e_data;
        logic [N-1:0]  e_cred;
        e_tx   = (m_owner >= 0) && b_tx[m_owner];
        e_data = e_tx ? cur[m_owner] : '0;
        e_cred = '0;
        if (m_owner >= 0) e_cred[m_owner] = credit_i;
        check("tx_o",   32'(tx_o),         32'(e_tx));
        check("data_o", data_o,            e_data);
        check("credit", 32'(src_credit_o), 32'(e_cred));
    endtask

    // what the upcoming rising edge does, by the arbitration rules
    task automatic edge_update();
        int   old;
        logic xfer;
        logic eoa_n;
        old   = m_owner;
        xfer  = (old >= 0) && b_tx[old] && credit_i;
        eoa_n = (&b_eoa) && (old < 0) && (b_tx == '0);
        if (old < 0) begin
            if (b_tx != '0) begin
                m_owner = rr_pick(b_tx, m_last);
                m_grant = m_owner;
                m_cnt   = '0;
            end
        end else if (!b_tx[old]) begin
            m_last  = old;
            m_owner = -1;
        end else if (credit_i && (m_cnt != 32'hFFFF_FFFF)) begin
            m_cnt = m_cnt + 32'd1;
        end
        m_eoa = eoa_n;
        if (xfer) begin
            rem[old]--;
            cur[old] = $urandom;
            if (rem[old] == 0) begin
                b_tx[old] = 1'b0;
                cool[old] = 1'b1;
            end
        end
    endtask

    initial begin
        rst_ni     = 1'b0;
        credit_i   = 1'b0;
        b_tx       = '0;
        b_eoa      = '0;
        allow_new  = 1'b1;
        did_reset  = 1'b0;
        eoa_seen   = 1'b0;
        for (int k = 0; k < N; k++) begin
            cur[k]  = $urandom;
            rem[k]  = 0;
            cool[k] = 1'b0;
        end
        apply_inputs();
        model_reset();
        #3;
        check_regs();
        check_comb();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_regs();
            if (eoa_o === 1'b1) eoa_seen = 1'b1;
            if (cyc == 2600) begin
                allow_new = 1'b0;
                b_eoa     = '1;
            end
            // driver: idle sources may open a new packet stream
            for (int k = 0; k < N; k++) begin
                if (!b_tx[k]) begin
                    if (cool[k]) begin
                        cool[k] = 1'b0;
                    end else if ((allow_new && ($urandom_range(0, 7) == 0)) ||
                                 (cyc == 2900 && k == 1)) begin
                        b_tx[k] = 1'b1;
                        rem[k]  = $urandom_range(1, 6);
                        cur[k]  = $urandom;
                    end
                end
            end
            credit_i = ($urandom_range(0, 9) < 7);
            apply_inputs();
            #1;
            check_comb();
            if (!did_reset && cyc >= 1200 && m_owner >= 0 && b_tx[m_owner]) begin
                did_reset = 1'b1;
                rst_ni = 1'b0;
                #1;
                check("rst_tx",     32'(tx_o),         32'd0);
                check("rst_busy",   32'(busy_o),       32'd0);
                check("rst_credit", 32'(src_credit_o), 32'd0);
                check("rst_data",   data_o,            32'd0);
                check("rst_grant",  32'(grant_o),      32'd0);
                check("rst_cnt",    flit_cnt_o,        32'd0);
                model_reset();
                for (int k = 0; k < N; k++) begin
                    rem[k]  = 0;
                    cool[k] = 1'b0;
                end
                b_tx = '0;
                apply_inputs();
                rst_ni = 1'b1;
                #1;
            end
            edge_update();
            @(negedge clk_i);
        end

        check("eoa_seen", 32'(eoa_seen), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
